// File: rtl/conv_result_streamer_if.sv
// rtl/conv_result_streamer_if.sv - sample stream from the result streamer to its sink
interface conv_result_streamer_if #(
    parameter int N = 8
) ();
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [15:0]   m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic [IW-1:0] m_index;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        output m_index,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        input  m_index,
        output m_ready
    );
endinterface

// File: rtl/conv_result_streamer.sv
// rtl/conv_result_streamer.sv - captures a FIR result frame and streams it one sample per beat
module conv_result_streamer #(
    parameter  int LEN             = 19,
    parameter  int SIGNAL_LENGTH_1 = 2400,
    localparam int N               = LEN + SIGNAL_LENGTH_1 + 1,
    localparam int IW              = (N > 1) ? $clog2(N) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N*16:0]          flatten_conv_result,
    input  logic                   is_completed,
    conv_result_streamer_if.master m,
    output logic                   busy,
    output logic                   frame_done
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    state_t          state_q;
    logic [N*16-1:0] buf_q;
    logic            valid_q;
    logic            last_q;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   idx_d;
    logic            busy_q;
    logic            done_q;
    logic            is_completed_q;
    logic            done_rise;
    logic            unused_msb;

    assign unused_msb = flatten_conv_result[N*16];
    assign done_rise  = is_completed & ~is_completed_q;
    assign idx_d      = idx_q + 1'b1;

    // The buffer shifts down one sample per beat, so the current sample is always
    // the low 16 bits: registered output with no wide read mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            buf_q          <= '0;
            valid_q        <= 1'b0;
            last_q         <= 1'b0;
            idx_q          <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            is_completed_q <= 1'b0;
        end else begin
            is_completed_q <= is_completed;
            done_q         <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (done_rise) begin
                        buf_q   <= flatten_conv_result[N*16-1:0];
                        valid_q <= 1'b1;
                        idx_q   <= '0;
                        last_q  <= (N == 1);
                        busy_q  <= 1'b1;
                        state_q <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (valid_q && m.m_ready) begin
                        buf_q <= buf_q >> 16;
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            idx_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            idx_q  <= idx_d;
                            last_q <= (idx_d == IDX_LAST);
                        end
                    end
                end
                S_DONE: begin
                    // An is_completed edge landing here is dropped on purpose: only IDLE arms.
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign m.m_data    = buf_q[15:0];
    assign m.m_valid   = valid_q;
    assign m.m_last    = last_q;
    assign m.m_index   = idx_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
endmodule

// File: tb/tb_conv_result_streamer.sv
// tb/tb_conv_result_streamer.sv - scoreboard bench for conv_result_streamer with N=8
module tb_conv_result_streamer;
    localparam int LEN = 3;
    localparam int SL  = 4;
    localparam int N   = 8;
    localparam int IW  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          is_completed = 1'b0;
    logic [N*16:0] flat = '0;
    logic          busy;
    logic          frame_done;

    always #5 clk = ~clk;

    conv_result_streamer_if #(.N(N)) s_if ();

    conv_result_streamer #(.LEN(LEN), .SIGNAL_LENGTH_1(SL)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .flatten_conv_result (flat),
        .is_completed        (is_completed),
        .m                   (s_if.master),
        .busy                (busy),
        .frame_done          (frame_done)
    );

    typedef struct {
        logic [15:0]   data;
        logic [IW-1:0] idx;
        logic          last;
    } exp_t;

    // retrig: 0 none, 1 extra edge mid-stream, 2 edge in the DONE cycle
    typedef struct {
        logic [7:0][15:0] smp;
        logic [31:0]      ready_pat;
        bit               hold;
        bit               corrupt;
        int               retrig;
        int               exp_beats;
        int               idle_n;
    } vec_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    int   beat_cnt = 0;
    int   fd_cnt   = 0;

    logic          prev_stall = 1'b0;
    logic [15:0]   prev_data;
    logic [IW-1:0] prev_idx;
    logic          prev_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard on each handshake, checks stall stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(s_if.m_valid), 32'd1);
                check("hold_data", 32'(s_if.m_data), 32'(prev_data));
                check("hold_index", 32'(s_if.m_index), 32'(prev_idx));
                check("hold_last", 32'(s_if.m_last), 32'(prev_last));
            end
            if (s_if.m_valid && s_if.m_ready) begin
                beat_cnt++;
                check("beat_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("beat_data", 32'(s_if.m_data), 32'(e.data));
                    check("beat_index", 32'(s_if.m_index), 32'(e.idx));
                    check("beat_last", 32'(s_if.m_last), 32'(e.last));
                end
            end
            if (frame_done) fd_cnt++;
            prev_stall = s_if.m_valid && !s_if.m_ready;
            prev_data  = s_if.m_data;
            prev_idx   = s_if.m_index;
            prev_last  = s_if.m_last;
        end
    end

    function automatic logic [N*16:0] pack(input logic [7:0][15:0] s, input logic msb);
        return {msb, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input vec_t v);
        int  b0;
        int  f0;
        bit  done;
        bit  last_hs;
        bit  any_valid;
        flat = pack(v.smp, 1'($urandom_range(0, 1)));
        for (int k = 0; k < N; k++) sb.push_back('{v.smp[k], IW'(k), (k == N - 1)});
        b0 = beat_cnt;
        f0 = fd_cnt;
        check("pre_valid", 32'(s_if.m_valid), 32'd0);
        s_if.m_ready = 1'b0;
        is_completed = 1'b1;
        tick();
        check("lat_valid", 32'(s_if.m_valid), 32'd1);
        check("lat_index", 32'(s_if.m_index), 32'd0);
        check("lat_busy", 32'(busy), 32'd1);
        check("lat_data", 32'(s_if.m_data), 32'(v.smp[0]));
        if (!v.hold) is_completed = 1'b0;
        done    = 1'b0;
        last_hs = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            s_if.m_ready = v.ready_pat[c % 32];
            if (v.corrupt && c == 2) flat = '1;
            if (v.retrig == 1 && c == 3) is_completed = 1'b1;
            if (v.retrig == 1 && c == 5) is_completed = 1'b0;
            last_hs = s_if.m_valid && s_if.m_ready && s_if.m_last;
            tick();
            if (frame_done) done = 1'b1;
        end
        check("frame_done_seen", 32'(done), 32'd1);
        check("done_after_last", 32'(last_hs), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_valid", 32'(s_if.m_valid), 32'd0);
        check("done_index", 32'(s_if.m_index), 32'd0);
        check("beat_count", 32'(beat_cnt - b0), 32'(v.exp_beats));
        check("sb_drained", 32'(sb.size()), 32'd0);
        s_if.m_ready = 1'b1;
        if (v.retrig == 2) is_completed = 1'b1;
        any_valid = 1'b0;
        for (int i = 0; i < v.idle_n; i++) begin
            tick();
            if (i == 0) check("fd_one_cycle", 32'(frame_done), 32'd0);
            if (s_if.m_valid) any_valid = 1'b1;
        end
        check("idle_no_valid", 32'(any_valid), 32'd0);
        check("fd_pulses", 32'(fd_cnt - f0), 32'd1);
        is_completed = 1'b0;
        s_if.m_ready = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        vec_t v;
        logic [15:0] neg[8];
        bit any_valid;
        int guard;

        neg = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0001, 16'h8000, 16'hFFFF, 16'h0000, 16'h8001};
        for (int i = 0; i < 5; i++) begin
            vecs[i].ready_pat = 32'hFFFF_FFFF;
            vecs[i].hold      = 1'b0;
            vecs[i].corrupt   = 1'b0;
            vecs[i].retrig    = 0;
            vecs[i].exp_beats = N;
            vecs[i].idle_n    = 6;
            for (int k = 0; k < N; k++) vecs[i].smp[k] = 16'h1000 + 16'(k);
        end
        vecs[1].ready_pat = 32'h9999_9999;
        vecs[1].retrig    = 1;
        vecs[2].hold      = 1'b1;
        vecs[2].corrupt   = 1'b1;
        vecs[2].idle_n    = 30;
        for (int k = 0; k < N; k++) vecs[3].smp[k] = neg[k];
        vecs[3].retrig    = 2;
        for (int k = 0; k < N; k++) vecs[4].smp[k] = 16'h2000 + 16'(k * 16'h0111);
        vecs[4].ready_pat = 32'h6DB6_D5A5;

        s_if.m_ready = 1'b0;
        any_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            is_completed = ~is_completed;
            s_if.m_ready = ~s_if.m_ready;
            if (s_if.m_valid) any_valid = 1'b1;
        end
        check("rst_no_valid", 32'(any_valid), 32'd0);
        check("rst_data", 32'(s_if.m_data), 32'd0);
        check("rst_last", 32'(s_if.m_last), 32'd0);
        check("rst_index", 32'(s_if.m_index), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        is_completed = 1'b0;
        s_if.m_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", 32'(s_if.m_valid), 32'd0);

        for (int i = 0; i < 5; i++) run_frame(vecs[i]);

        // Reset in the middle of a frame, then a fresh edge streams a full frame.
        v = vecs[0];
        flat = pack(v.smp, 1'b0);
        for (int k = 0; k < N; k++) sb.push_back('{v.smp[k], IW'(k), (k == N - 1)});
        is_completed = 1'b1;
        s_if.m_ready = 1'b1;
        guard = 0;
        while (s_if.m_index != 3'd3 && guard < 20) begin
            tick();
            guard++;
        end
        check("mid_reached_beat3", 32'(s_if.m_index), 32'd3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(s_if.m_valid), 32'd0);
        check("mid_rst_index", 32'(s_if.m_index), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_last", 32'(s_if.m_last), 32'd0);
        sb.delete();
        is_completed = 1'b0;
        tick();
        rst_n = 1'b1;
        any_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (s_if.m_valid) any_valid = 1'b1;
        end
        check("mid_rst_no_resume", 32'(any_valid), 32'd0);
        s_if.m_ready = 1'b0;
        run_frame(vecs[0]);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/conv_result_streamer.md
Name: conv_result_streamer

Overview:
- Consumer end of the FIR result interface: captures the flattened convolution result when the FIR raises is_completed.
- Serializes the captured result into a stream of 16-bit samples, one sample per valid/ready handshake, index 0 first.
- Sits between the FIR core (non-pipelined or pipelined) and a downstream sink such as a UART/DMA writer or a result RAM, replacing bulk flattened-bus readout.

Parameters:
- LEN, 19, coefficient count minus 1 (matches the FIR core).
- SIGNAL_LENGTH_1, 2400, signal sample count minus 1 (matches the FIR core).
- Derived, not overridable: N = LEN+SIGNAL_LENGTH_1+1 result samples; IW = clog2(N) index width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flatten_conv_result  in  N*16+1  FIR result bus; sample k = bits [k*16 +: 16]; bit N*16 ignored.
- is_completed  in  1  FIR done level.
- m_data  out  16  current sample (signed two's complement, passed through unmodified).
- m_valid  out  1  m_data holds a valid sample.
- m_ready  in  1  sink accepts the sample.
- m_last  out  1  high with m_valid on sample N-1.
- m_index  out  IW  index of the current sample.
- busy  out  1  frame captured and not yet fully streamed.
- frame_done  out  1  one-cycle pulse after the last handshake.

Behaviour:
- Reset (async assert, sync release): state=IDLE. m_data=0, m_valid=0, m_last=0, m_index=0, busy=0, frame_done=0, capture buffer=0, is_completed edge register=0.
- Edge detect: done_rise = is_completed & ~is_completed_q, with is_completed_q registered every cycle.
- IDLE:
  - On done_rise, latch the N*16 result bits into the buffer and go to STREAM.
  - Next cycle: m_valid=1, m_index=0, m_data=sample 0, busy=1. Latency from the done_rise edge to first m_valid is 1 clock.
- STREAM:
  - Handshake = m_valid & m_ready.
  - On a handshake with m_index<N-1: m_index increments, and m_data shows the next sample in the same cycle m_index changes (registered, no bubble). Back-to-back throughput is 1 sample/clock.
  - Without a handshake, m_data, m_index, m_valid and m_last hold stable. m_valid never drops once raised until the last beat.
  - m_last = m_valid & (m_index==N-1).
  - On a handshake with m_last: go to DONE. Next cycle: m_valid=0, busy=0, m_index=0, frame_done=1.
- DONE: lasts one cycle, then returns to IDLE. frame_done=0 in every other state.
- Re-arm: a new capture requires a fresh rising edge of is_completed seen in IDLE.
  - is_completed held high across a whole frame does not retrigger.
  - A rising edge during STREAM or DONE is ignored and not queued. The buffer is not overwritten mid-frame.
- Simultaneous done_rise in the DONE cycle: ignored (only IDLE captures).
- Reset mid-frame: outputs return to reset values immediately (asynchronous). No partial frame resumes. The next frame needs a new rising edge after release.
- m_ready is ignored when m_valid=0.
- The buffer is sampled only on the capture cycle. Later changes on flatten_conv_result have no effect on the stream.

Test Plan:
Use LEN=3, SIGNAL_LENGTH_1=4 (N=8), with sample k = 16'h1000+k unless noted.
- Reset -> all outputs 0; is_completed toggling with rst_n=0 produces no m_valid.
- is_completed rises, m_ready=1 constantly -> m_valid high 1 clk after the edge, 8 consecutive beats with data 1000..1007, m_last only on index 7, frame_done pulse the following cycle, busy low with it.
- m_ready toggled 1,0,0,1,... -> each sample held stable while ready=0, no sample skipped or duplicated, 8 total beats.
- is_completed held high for 40 clks, and flatten_conv_result changed to all FFFF mid-frame -> exactly one frame of 1000..1007, no second frame.
- rst_n pulsed low after beat 3 -> m_valid=0 and m_index=0 immediately, no further beats; fresh is_completed edge -> full frame from index 0.
- Negative samples (8000, FFFF) -> emitted bit-exact; second frame after returning to IDLE streams new data.
